// File: rtl/prt_scaler_pkg.sv
// Shared helpers and types for the parametrised scaler kernel.
// Geometry helpers are used by both the top level and the per-pixel MAC.
package prt_scaler_pkg;

  localparam int DEF_TAPS = 4;
  localparam int DEF_CBW  = 8;

  // Coefficient set for one output pixel at the default geometry; the top level
  // re-declares the same shape locally for its own parameter values.
  typedef logic [DEF_TAPS-1:0][DEF_CBW-1:0] coef_set_t;

  function automatic int f_selw(input int lines, input int win);
    return $clog2(lines * win);
  endfunction

  function automatic int f_krnl_lat(input int taps);
    return 3 + $clog2(taps);
  endfunction

  function automatic int f_max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/prt_scaler_krnl_n_mac.sv
// One output pixel: product register, registered adder tree, then round/saturate.
// The bypass flag and the tap-0 sample ride a delay line matched to the tree depth.
module prt_scaler_krnl_n_mac
  import prt_scaler_pkg::*;
#(
  parameter int P_BPC  = 8,
  parameter int P_TAPS = 4,
  parameter int P_CBW  = 8
) (
  input  logic                          CLK_IN,
  input  logic                          RST_IN,
  input  logic                          bypass,
  input  logic [P_TAPS-1:0][P_BPC-1:0]  tap_dat,
  input  logic [P_TAPS-1:0][P_CBW-1:0]  coef,
  output logic [P_BPC-1:0]              pix_dat
);

  localparam int LEVELS = f_krnl_lat(P_TAPS) - 3;
  localparam int NPAD   = 1 << LEVELS;
  localparam int SW     = P_BPC + P_CBW + LEVELS;
  localparam int NNODE  = 2 * NPAD - 1;

  // Heap layout: leaves hold the products, node n sums children 2n+1 and 2n+2,
  // so every tree level costs exactly one register stage.
  logic [SW-1:0] heap [NNODE];

  logic [LEVELS:0]             byp_d;
  logic [LEVELS:0][P_BPC-1:0]  t0_d;
  logic [SW:0]                 rnd;
  logic                        sat;
  logic [P_BPC-1:0]            rounded;
  logic                        unused_rnd_lsb;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      for (int n = 0; n < NNODE; n++) begin
        heap[n] <= '0;
      end
    end else begin
      for (int t = 0; t < P_TAPS; t++) begin
        heap[NPAD-1+t] <= SW'(tap_dat[t]) * SW'(coef[t]);
      end
      for (int t = P_TAPS; t < NPAD; t++) begin
        heap[NPAD-1+t] <= '0;
      end
      for (int n = 0; n < NPAD - 1; n++) begin
        heap[n] <= heap[2*n+1] + heap[2*n+2];
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      byp_d <= '0;
      t0_d  <= '0;
    end else begin
      byp_d <= {byp_d[LEVELS-1:0], bypass};
      t0_d  <= {t0_d[LEVELS-1:0], tap_dat[0]};
    end
  end

  always_comb begin
    rnd     = {1'b0, heap[0]} + ((SW+1)'(1) << (P_CBW - 1));
    sat     = |rnd[SW:P_BPC+P_CBW];
    rounded = rnd[P_BPC+P_CBW-1:P_CBW];
  end

  assign unused_rnd_lsb = ^rnd[P_CBW-1:0];

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      pix_dat <= '0;
    end else if (byp_d[LEVELS]) begin
      pix_dat <= t0_d[LEVELS];
    end else if (sat) begin
      pix_dat <= '1;
    end else begin
      pix_dat <= rounded;
    end
  end

endmodule

// File: rtl/prt_scaler_krnl_n.sv
// Multi-pixel scaler kernel: tap mux, double-buffered coefficients with a
// blanking-safe swap, per-pixel MAC pipelines and the matching DE delay line.
module prt_scaler_krnl_n
  import prt_scaler_pkg::*;
#(
  parameter int P_PPC   = 4,
  parameter int P_BPC   = 8,
  parameter int P_TAPS  = 4,
  parameter int P_LINES = 2,
  parameter int P_WIN   = 5,
  parameter int P_CBW   = 8,
  localparam int SELW   = f_selw(P_LINES, P_WIN),
  localparam int ADRW   = f_max1($clog2(P_PPC))
) (
  input  logic                              CLK_IN,
  input  logic                              RST_IN,
  input  logic                              AGNT_DE_IN,
  input  logic                              BYPASS_IN,
  input  logic [P_LINES*P_WIN*P_BPC-1:0]    SLW_DAT_IN,
  input  logic [P_PPC*P_TAPS*SELW-1:0]      MUX_SEL_IN,
  input  logic                              COEF_WR_IN,
  input  logic [ADRW-1:0]                   COEF_ADR_IN,
  input  logic [P_TAPS*P_CBW-1:0]           COEF_DAT_IN,
  input  logic                              COEF_UPD_IN,
  output logic                              COEF_PEND_OUT,
  output logic [P_PPC*P_BPC-1:0]            VID_DAT_OUT,
  output logic                              VID_DE_OUT
);

  localparam int NSMP = P_LINES * P_WIN;
  localparam int LAT  = f_krnl_lat(P_TAPS);

  logic [NSMP-1:0][P_BPC-1:0]               win;
  logic [P_PPC-1:0][P_TAPS-1:0][SELW-1:0]   sel;
  logic [P_PPC-1:0][P_TAPS-1:0][P_BPC-1:0]  mux_tap;
  logic [P_PPC-1:0][P_TAPS-1:0][P_BPC-1:0]  s0_tap;
  logic                                     s0_byp;

  logic [P_PPC-1:0][P_TAPS-1:0][P_CBW-1:0]  coef_shd;
  logic [P_PPC-1:0][P_TAPS-1:0][P_CBW-1:0]  coef_act;
  logic                                     coef_pend;
  logic                                     swap_go;

  logic [LAT-1:0]                           de_sr;
  logic [P_BPC-1:0]                         pix [P_PPC];

  assign win = SLW_DAT_IN;
  assign sel = MUX_SEL_IN;

  // Selects beyond the window contribute a zero sample.
  always_comb begin
    mux_tap = '0;
    for (int p = 0; p < P_PPC; p++) begin
      for (int t = 0; t < P_TAPS; t++) begin
        if (32'(sel[p][t]) < NSMP) begin
          mux_tap[p][t] = win[sel[p][t]];
        end
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      s0_tap <= '0;
      s0_byp <= 1'b0;
    end else begin
      s0_tap <= mux_tap;
      s0_byp <= BYPASS_IN;
    end
  end

  // The swap waits for blanking so a line never mixes coefficient sets; it
  // copies the shadow as it stood before any write landing in the same cycle.
  assign swap_go = (coef_pend | COEF_UPD_IN) & ~AGNT_DE_IN;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      coef_shd  <= '0;
      coef_act  <= '0;
      coef_pend <= 1'b0;
    end else begin
      if (swap_go) begin
        coef_act <= coef_shd;
      end
      if (COEF_WR_IN && (32'(COEF_ADR_IN) < P_PPC)) begin
        coef_shd[COEF_ADR_IN] <= COEF_DAT_IN;
      end
      coef_pend <= (coef_pend | COEF_UPD_IN) & AGNT_DE_IN;
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      de_sr <= '0;
    end else begin
      de_sr <= {de_sr[LAT-2:0], AGNT_DE_IN};
    end
  end

  assign VID_DE_OUT    = de_sr[LAT-1];
  assign COEF_PEND_OUT = coef_pend;

  for (genvar p = 0; p < P_PPC; p++) begin : g_pix
    prt_scaler_krnl_n_mac #(
      .P_BPC  (P_BPC),
      .P_TAPS (P_TAPS),
      .P_CBW  (P_CBW)
    ) u_mac (
      .CLK_IN  (CLK_IN),
      .RST_IN  (RST_IN),
      .bypass  (s0_byp),
      .tap_dat (s0_tap[p]),
      .coef    (coef_act[p]),
      .pix_dat (pix[p])
    );
  end

  always_comb begin
    VID_DAT_OUT = '0;
    for (int p = 0; p < P_PPC; p++) begin
      VID_DAT_OUT[p*P_BPC +: P_BPC] = pix[p];
    end
  end

endmodule

// File: tb/tb_prt_scaler_krnl_n.sv
// Scoreboard bench: a default-geometry kernel under directed steps and a
// wide 2-ppc/8-tap/10-bit kernel under random vectors, both against a reference model.
module tb_prt_scaler_krnl_n;

  localparam int LAT1 = 5;
  localparam int LAT2 = 6;

  typedef struct {
    int          due;
    logic [31:0] dat;
  } sb_t;

  logic CLK_IN = 1'b0;
  logic RST_IN;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  sb_t  sb1[$];
  sb_t  sb2[$];

  // default kernel ports
  logic        de1, byp1_i, wr1_i, upd1_i, pend1, vde1;
  logic [79:0] slw1;
  logic [63:0] sel1_i;
  logic [1:0]  adr1_i;
  logic [31:0] cdat1;
  logic [31:0] vdat1;

  // wide kernel ports
  logic         de2, byp2_i, wr2_i, upd2_i, pend2, vde2;
  logic [149:0] slw2;
  logic [63:0]  sel2_i;
  logic         adr2_i;
  logic [63:0]  cdat2;
  logic [19:0]  vdat2;

  // stimulus and model state
  int w1[10];
  int s1[4][4];
  int st1_dat[4];
  int m1_sh[4][4];
  int m1_act[4][4];
  bit st1_de, st1_byp, st1_wr, st1_upd, m1_pend;
  int st1_adr;

  int w2[15];
  int s2[2][8];
  int st2_dat[8];
  int m2_sh[2][8];
  int m2_act[2][8];
  bit st2_de, st2_byp, st2_wr, st2_upd, m2_pend;
  int st2_adr;

  always #5 CLK_IN = ~CLK_IN;
  always @(posedge CLK_IN) cyc <= cyc + 1;

  prt_scaler_krnl_n u_dut1 (
    .CLK_IN        (CLK_IN),
    .RST_IN        (RST_IN),
    .AGNT_DE_IN    (de1),
    .BYPASS_IN     (byp1_i),
    .SLW_DAT_IN    (slw1),
    .MUX_SEL_IN    (sel1_i),
    .COEF_WR_IN    (wr1_i),
    .COEF_ADR_IN   (adr1_i),
    .COEF_DAT_IN   (cdat1),
    .COEF_UPD_IN   (upd1_i),
    .COEF_PEND_OUT (pend1),
    .VID_DAT_OUT   (vdat1),
    .VID_DE_OUT    (vde1)
  );

  prt_scaler_krnl_n #(
    .P_PPC   (2),
    .P_BPC   (10),
    .P_TAPS  (8),
    .P_LINES (3),
    .P_WIN   (5),
    .P_CBW   (8)
  ) u_dut2 (
    .CLK_IN        (CLK_IN),
    .RST_IN        (RST_IN),
    .AGNT_DE_IN    (de2),
    .BYPASS_IN     (byp2_i),
    .SLW_DAT_IN    (slw2),
    .MUX_SEL_IN    (sel2_i),
    .COEF_WR_IN    (wr2_i),
    .COEF_ADR_IN   (adr2_i),
    .COEF_DAT_IN   (cdat2),
    .COEF_UPD_IN   (upd2_i),
    .COEF_PEND_OUT (pend2),
    .VID_DAT_OUT   (vdat2),
    .VID_DE_OUT    (vde2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int ref_pix(input int smp[8], input int cf[8], input int ntaps,
                                 input int bpc, input int cbw, input bit byp);
    longint acc;
    longint r;
    if (byp) return smp[0];
    acc = 0;
    for (int t = 0; t < ntaps; t++) acc += longint'(smp[t]) * longint'(cf[t]);
    r = (acc + (longint'(1) << (cbw - 1))) >> cbw;
    if (r > (longint'(1) << bpc) - 1) r = (longint'(1) << bpc) - 1;
    return int'(r);
  endfunction

  task automatic applyStimulus();
    sb_t         e;
    int          smp[8];
    int          cf[8];
    logic [31:0] exp_v;
    de1    = st1_de;
    byp1_i = st1_byp;
    wr1_i  = st1_wr;
    upd1_i = st1_upd;
    adr1_i = 2'(st1_adr);
    for (int i = 0; i < 10; i++) slw1[i*8 +: 8] = 8'(w1[i]);
    for (int p = 0; p < 4; p++)
      for (int t = 0; t < 4; t++) sel1_i[(p*4+t)*4 +: 4] = 4'(s1[p][t]);
    for (int t = 0; t < 4; t++) cdat1[t*8 +: 8] = 8'(st1_dat[t]);
    if (st1_de) begin
      exp_v = '0;
      for (int p = 0; p < 4; p++) begin
        for (int t = 0; t < 8; t++) begin smp[t] = 0; cf[t] = 0; end
        for (int t = 0; t < 4; t++) begin
          smp[t] = (s1[p][t] < 10) ? w1[s1[p][t]] : 0;
          cf[t]  = m1_act[p][t];
        end
        exp_v[p*8 +: 8] = 8'(ref_pix(smp, cf, 4, 8, 8, st1_byp));
      end
      e.due = cyc + LAT1;
      e.dat = exp_v;
      sb1.push_back(e);
    end
    if ((m1_pend || st1_upd) && !st1_de) m1_act = m1_sh;
    if (st1_wr && st1_adr < 4)
      for (int t = 0; t < 4; t++) m1_sh[st1_adr][t] = st1_dat[t];
    m1_pend = (m1_pend || st1_upd) && st1_de;
    @(posedge CLK_IN);
    #1;
    st1_wr  = 1'b0;
    st1_upd = 1'b0;
  endtask

  task automatic applyStimulusWide();
    sb_t         e;
    int          smp[8];
    int          cf[8];
    logic [31:0] exp_v;
    de2    = st2_de;
    byp2_i = st2_byp;
    wr2_i  = st2_wr;
    upd2_i = st2_upd;
    adr2_i = 1'(st2_adr);
    for (int i = 0; i < 15; i++) slw2[i*10 +: 10] = 10'(w2[i]);
    for (int p = 0; p < 2; p++)
      for (int t = 0; t < 8; t++) sel2_i[(p*8+t)*4 +: 4] = 4'(s2[p][t]);
    for (int t = 0; t < 8; t++) cdat2[t*8 +: 8] = 8'(st2_dat[t]);
    if (st2_de) begin
      exp_v = '0;
      for (int p = 0; p < 2; p++) begin
        for (int t = 0; t < 8; t++) begin
          smp[t] = (s2[p][t] < 15) ? w2[s2[p][t]] : 0;
          cf[t]  = m2_act[p][t];
        end
        exp_v[p*10 +: 10] = 10'(ref_pix(smp, cf, 8, 10, 8, st2_byp));
      end
      e.due = cyc + LAT2;
      e.dat = exp_v;
      sb2.push_back(e);
    end
    if ((m2_pend || st2_upd) && !st2_de) m2_act = m2_sh;
    if (st2_wr && st2_adr < 2)
      for (int t = 0; t < 8; t++) m2_sh[st2_adr][t] = st2_dat[t];
    m2_pend = (m2_pend || st2_upd) && st2_de;
    @(posedge CLK_IN);
    #1;
    st2_wr  = 1'b0;
    st2_upd = 1'b0;
  endtask

  // Pop one expected entry per output beat and check both timing and data.
  always @(negedge CLK_IN) begin : mon1
    sb_t e;
    if (RST_IN === 1'b0 && vde1 === 1'b1) begin
      if (sb1.size() == 0) begin
        checkOutput("de1_spurious", 32'(vde1), 32'd0);
      end else begin
        e = sb1.pop_front();
        checkOutput("lat1", cyc, e.due);
        checkOutput("pix1", vdat1, e.dat);
      end
    end
  end

  always @(negedge CLK_IN) begin : mon2
    sb_t e;
    if (RST_IN === 1'b0 && vde2 === 1'b1) begin
      if (sb2.size() == 0) begin
        checkOutput("de2_spurious", 32'(vde2), 32'd0);
      end else begin
        e = sb2.pop_front();
        checkOutput("lat2", cyc, e.due);
        checkOutput("pix2", 32'(vdat2), e.dat);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    RST_IN = 1'b1;
    de1 = 0; byp1_i = 0; wr1_i = 0; upd1_i = 0; adr1_i = '0; slw1 = '0; sel1_i = '0; cdat1 = '0;
    de2 = 0; byp2_i = 0; wr2_i = 0; upd2_i = 0; adr2_i = '0; slw2 = '0; sel2_i = '0; cdat2 = '0;
    st1_de = 0; st1_byp = 0; st1_wr = 0; st1_upd = 0; st1_adr = 0; m1_pend = 0;
    st2_de = 0; st2_byp = 0; st2_wr = 0; st2_upd = 0; st2_adr = 0; m2_pend = 0;
    foreach (m1_sh[i, j]) begin m1_sh[i][j] = 0; m1_act[i][j] = 0; end
    foreach (m2_sh[i, j]) begin m2_sh[i][j] = 0; m2_act[i][j] = 0; end
    foreach (st1_dat[i]) st1_dat[i] = 0;
    foreach (st2_dat[i]) st2_dat[i] = 0;
    foreach (w1[i]) w1[i] = 0;
    foreach (w2[i]) w2[i] = 0;
    foreach (s1[i, j]) s1[i][j] = 0;
    foreach (s2[i, j]) s2[i][j] = 0;

    repeat (3) @(posedge CLK_IN);
    #1;
    checkOutput("rst_dat1", vdat1, 32'd0);
    checkOutput("rst_de1", 32'(vde1), 32'd0);
    checkOutput("rst_pend1", 32'(pend1), 32'd0);
    checkOutput("rst_dat2", 32'(vdat2), 32'd0);
    checkOutput("rst_de2", 32'(vde2), 32'd0);
    RST_IN = 1'b0;
    $display("[TB] reset released at cycle %0d", cyc);

    // load shadow banks during blanking, then swap immediately
    st1_wr = 1; st1_adr = 0; st1_dat = '{128, 128, 0, 0};     applyStimulus();
    st1_wr = 1; st1_adr = 1; st1_dat = '{64, 64, 64, 64};     applyStimulus();
    st1_wr = 1; st1_adr = 2; st1_dat = '{1, 0, 0, 0};         applyStimulus();
    st1_wr = 1; st1_adr = 3; st1_dat = '{255, 255, 255, 255}; applyStimulus();
    st1_upd = 1; applyStimulus();
    checkOutput("pend_no_rise", 32'(pend1), 32'd0);

    // unity, rounding, saturation and out-of-range select
    w1 = '{100, 128, 255, 255, 37, 10, 20, 30, 40, 50};
    s1 = '{'{0, 0, 5, 6}, '{0, 1, 2, 15}, '{1, 7, 8, 9}, '{2, 3, 2, 3}};
    st1_de = 1; applyStimulus();
    for (int k = 0; k < 4; k++) begin
      foreach (w1[i]) w1[i] = $urandom_range(0, 255);
      foreach (s1[i, j]) s1[i][j] = $urandom_range(0, 15);
      applyStimulus();
    end

    // deferred swap with repeated update requests
    w1 = '{100, 128, 255, 255, 37, 10, 20, 30, 40, 50};
    s1 = '{'{0, 0, 5, 6}, '{0, 1, 2, 15}, '{1, 7, 8, 9}, '{2, 3, 2, 3}};
    st1_wr = 1; st1_adr = 0; st1_dat = '{0, 0, 128, 128}; applyStimulus();
    st1_upd = 1; applyStimulus();
    checkOutput("pend_set", 32'(pend1), 32'd1);
    st1_upd = 1; applyStimulus();
    checkOutput("pend_hold", 32'(pend1), 32'd1);
    applyStimulus();
    st1_de = 0; applyStimulus();
    checkOutput("pend_clear", 32'(pend1), 32'd0);
    st1_de = 1; applyStimulus(); applyStimulus();

    // swap and shadow write in the same blanking cycle
    st1_upd = 1; applyStimulus();
    st1_de = 0; st1_wr = 1; st1_adr = 1; st1_dat = '{200, 0, 0, 0}; applyStimulus();
    checkOutput("pend_clear2", 32'(pend1), 32'd0);
    st1_de = 1; applyStimulus();
    st1_de = 0; st1_upd = 1; applyStimulus();
    st1_de = 1; applyStimulus();

    // single-cycle bypass with tap 0 = 37
    for (int p = 0; p < 4; p++) s1[p][0] = 4;
    applyStimulus();
    st1_byp = 1; applyStimulus();
    st1_byp = 0; applyStimulus();

    for (int k = 0; k < 40; k++) begin
      st1_de  = ($urandom_range(0, 3) != 0);
      st1_byp = ($urandom_range(0, 7) == 0);
      foreach (w1[i]) w1[i] = $urandom_range(0, 255);
      foreach (s1[i, j]) s1[i][j] = $urandom_range(0, 15);
      applyStimulus();
    end

    // asynchronous reset in the middle of an active line
    st1_de = 1; st1_byp = 0; st1_upd = 1;
    w1 = '{100, 128, 255, 255, 37, 10, 20, 30, 40, 50};
    s1 = '{'{0, 0, 5, 6}, '{0, 1, 2, 15}, '{1, 7, 8, 9}, '{2, 3, 2, 3}};
    applyStimulus();
    checkOutput("pend_pre_rst", 32'(pend1), 32'd1);
    applyStimulus(); applyStimulus(); applyStimulus(); applyStimulus(); applyStimulus();
    #2;
    RST_IN = 1'b1;
    #1;
    sb1.delete();
    checkOutput("midrst_dat1", vdat1, 32'd0);
    checkOutput("midrst_de1", 32'(vde1), 32'd0);
    checkOutput("midrst_pend1", 32'(pend1), 32'd0);
    foreach (m1_sh[i, j]) begin m1_sh[i][j] = 0; m1_act[i][j] = 0; end
    m1_pend = 0;
    @(posedge CLK_IN);
    #1;
    RST_IN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      if (k < 4) checkOutput("de_hold_after_rst", 32'(vde1), 32'd0);
    end
    st1_de = 0; applyStimulus();

    // wide kernel: load both pixels, swap in blanking, then random vectors
    for (int p = 0; p < 2; p++) begin
      st2_wr = 1; st2_adr = p;
      foreach (st2_dat[t]) st2_dat[t] = $urandom_range(0, 63);
      applyStimulusWide();
    end
    st2_upd = 1; applyStimulusWide();
    checkOutput("pend2_no_rise", 32'(pend2), 32'd0);
    for (int k = 0; k < 1000; k++) begin
      st2_de  = ($urandom_range(0, 3) != 0);
      st2_byp = ($urandom_range(0, 15) == 0);
      foreach (w2[i]) w2[i] = $urandom_range(0, 1023);
      foreach (s2[i, j]) s2[i][j] = $urandom_range(0, 15);
      applyStimulusWide();
    end

    de1 = 1'b0;
    de2 = 1'b0;
    repeat (LAT2 + 3) @(posedge CLK_IN);
    #1;
    checkOutput("sb1_drained", sb1.size(), 32'd0);
    checkOutput("sb2_drained", sb2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prt_scaler_krnl_n.md
Name: prt_scaler_krnl_n

Overview:
Parametrised successor to the fixed 4-ppc scaler kernel. For each of P_PPC output pixels it selects P_TAPS samples from a multi-line sliding window, multiplies them by per-pixel coefficients, and rounds and saturates the sum.
- Adds double-buffered coefficients with a blanking-safe swap, a bypass mode, and a fully registered, depth-parametrised pipeline.
- Sits between the scaler agent/sliding-window and the scaler output stage.

Parameters:
P_PPC, 4, output pixels per clock (1..8)
P_BPC, 8, bits per component (8..16)
P_TAPS, 4, taps per output pixel (2..8)
P_LINES, 2, window lines (1..4)
P_WIN, 5, window samples per line
P_CBW, 8, coefficient width (unsigned, weights sum nominally to 2^P_CBW)

Ports:
CLK_IN  in  1  clock
RST_IN  in  1  reset, asynchronous, active-high
AGNT_DE_IN  in  1  input data enable
BYPASS_IN  in  1  1 = output tap-0 sample unweighted
SLW_DAT_IN  in  P_LINES*P_WIN*P_BPC  window; line l sample w at index (l*P_WIN+w)*P_BPC
MUX_SEL_IN  in  P_PPC*P_TAPS*SELW  tap selects; SELW=clog2(P_LINES*P_WIN); pixel p tap t at (p*P_TAPS+t)*SELW
COEF_WR_IN  in  1  write shadow coefficients
COEF_ADR_IN  in  max(1,clog2(P_PPC))  target output pixel
COEF_DAT_IN  in  P_TAPS*P_CBW  coefficients, tap t at t*P_CBW
COEF_UPD_IN  in  1  request shadow->active swap (pulse)
COEF_PEND_OUT  out  1  swap requested, not yet taken
VID_DAT_OUT  out  P_PPC*P_BPC  pixel p at p*P_BPC
VID_DE_OUT  out  1  output data enable

Behaviour:
- Reset (async assert; release synchronous to CLK_IN):
  - all pipeline registers, shadow and active coefficients, and the pending flag clear to 0;
  - VID_DAT_OUT=0, VID_DE_OUT=0, COEF_PEND_OUT=0.
- Pipeline, latency L = 3 + clog2(P_TAPS) cycles (L=5 at defaults):
  - S0 mux register: each select picks the window sample; select >= P_LINES*P_WIN yields 0.
  - S1 product register: P_BPC x P_CBW unsigned products.
  - S2.. adder tree: one register per level, clog2(P_TAPS) levels; width P_BPC+P_CBW+clog2(P_TAPS), no overflow.
  - Final register: out = (sum + 2^(P_CBW-1)) >> P_CBW, saturated to 2^P_BPC-1.
- Data path runs every cycle regardless of DE. VID_DE_OUT is AGNT_DE_IN delayed exactly L cycles.
- Bypass:
  - BYPASS_IN is sampled in S0 and travels with its data, so mid-stream toggles are sample-accurate.
  - When set, the final stage outputs that pixel's S0 tap-0 sample unchanged. Latency is still L.
- Coefficient write: with COEF_WR_IN=1, shadow[COEF_ADR_IN] <= COEF_DAT_IN. COEF_ADR_IN >= P_PPC: write ignored.
- Swap:
  - COEF_UPD_IN=1 sets the pending flag.
  - On any cycle with pending=1 and AGNT_DE_IN=0, active <= shadow (all pixels) and pending clears.
  - If COEF_UPD_IN=1 and AGNT_DE_IN=0 in the same cycle, the swap happens that cycle and COEF_PEND_OUT never rises.
  - While AGNT_DE_IN=1 the swap is deferred, so active coefficients never change mid-line.
- Simultaneous write and swap in one cycle: the swap copies the pre-write shadow; the write lands in shadow afterwards.
- Active coefficients feed S1. The first pixel of the next DE period uses the new set.
- Repeated COEF_UPD_IN while pending: no additional effect.

Decomposition:
- Package prt_scaler_pkg:
  - function f_selw(lines, win) = clog2(lines*win);
  - function f_krnl_lat(taps) = 3 + clog2(taps);
  - typedef for coefficient set, array of P_TAPS by P_CBW.
- Sub-module prt_scaler_krnl_n_mac:
  - handles one output pixel: multipliers, registered adder tree, round/saturate, bypass bypass-path;
  - instantiated P_PPC times.
- Tap mux, coefficient banks, swap control and DE delay line live in the top level.

Test Plan:
- Reset: assert RST_IN mid-stream with DE=1 -> outputs and COEF_PEND_OUT go 0 immediately; after release, VID_DE_OUT stays 0 for 5 cycles.
- Unity: pixel 0 coefs {128,128,0,0}, taps 0,1 on sample A=100, DE high -> pixel 0 = 100 exactly 5 cycles after DE.
- Rounding and saturation:
  - coefs {1,0,0,0} on sample 128 -> 1;
  - all coefs 255 on all-255 samples -> 255 (raw 1016 saturated).
- Deferred swap: write new shadow, pulse COEF_UPD_IN while DE=1 -> COEF_PEND_OUT=1 and output uses old coefs until DE falls; next line uses new coefs; pending clears.
- Bypass and out-of-range: toggle BYPASS_IN on one cycle with tap0=37 -> exactly that output = 37; select index 15 (window size 10) -> that tap contributes 0.
- Parametrisation: P_PPC=2, P_TAPS=8, P_LINES=3, P_BPC=10 -> latency 6, VID_DE_OUT aligned, 8-tap sum vs reference model over 1000 random vectors.
